// File: rtl/rc4_keystream_gen.sv
// RC4 keystream engine: runs the key schedule on request, then returns one
// PRGA byte per accepted genVal_i request with a valReady_o pulse.
// Optional RC4-drop[DROP_N] discard phase after key scheduling is enabled by
// defining the macro RC4_DROP_EN.
`timescale 1ns/1ps

module rc4_keystream_gen #(
   parameter int unsigned KEY_BYTES = 8
`ifdef RC4_DROP_EN
   , parameter int unsigned DROP_N = 256
`endif
) (
   input  logic                   clk,
   input  logic                   rst_i,
   input  logic                   genStateArr_i,
   input  logic [KEY_BYTES*8-1:0] key_i,
   input  logic                   genVal_i,
   output logic                   sarrGenerated_o,
   output logic                   valReady_o,
   output logic [7:0]             outputToXor_o,
   output logic                   busy_o
);

   localparam int unsigned KEY_W  = KEY_BYTES * 8;
   localparam int unsigned KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
`ifdef RC4_DROP_EN
   localparam int unsigned DROP_W = (DROP_N > 1) ? $clog2(DROP_N) : 1;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_KSA,
`ifdef RC4_DROP_EN
      ST_DROP,
`endif
      ST_READY,
      ST_PRGA_SWAP,
      ST_PRGA_OUT
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         i_q, i_d;
   logic [7:0]         j_q, j_d;
   logic [KIDX_W-1:0]  kidx_q, kidx_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic               served_q, served_d;
   logic               sarr_q, sarr_d;
   logic               val_q, val_d;
   logic [7:0]         out_q, out_d;
   logic               busy_q, busy_d;
`ifdef RC4_DROP_EN
   logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic               drop_ph_q, drop_ph_d;
`endif

   // State array: no reset, contents are rebuilt by INIT before use
   logic [7:0]         s_q [256];
   logic               s_init_c;
   logic               s_swap_c;
   logic [7:0]         s_a_c;
   logic [7:0]         s_b_c;

   logic [7:0]         key_byte_c;
   logic [7:0]         i_inc_c;
   logic [7:0]         j_ksa_c;
   logic [7:0]         j_prga_c;
   logic [7:0]         t_c;
   logic [7:0]         ks_c;

   // Select key byte (i mod KEY_BYTES) tracked by a wrapping key index
   always_comb begin
      key_byte_c = 8'h00;
      for (int k = 0; k < int'(KEY_BYTES); k++) begin
         if (kidx_q == KIDX_W'(k)) key_byte_c = key_q[8*k +: 8];
      end
   end

   // Index arithmetic for KSA and PRGA steps, all mod 256
   always_comb begin
      i_inc_c  = i_q + 8'd1;
      j_ksa_c  = j_q + s_q[i_q] + key_byte_c;
      j_prga_c = j_q + s_q[i_inc_c];
      t_c      = s_q[i_q] + s_q[j_q];
      ks_c     = s_q[t_c];
   end

   // Next-state and output logic
   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      j_d      = j_q;
      kidx_d   = kidx_q;
      key_d    = key_q;
      served_d = served_q;
      sarr_d   = 1'b0;
      val_d    = 1'b0;
      out_d    = out_q;
      s_init_c = 1'b0;
      s_swap_c = 1'b0;
      s_a_c    = i_q;
      s_b_c    = j_q;
`ifdef RC4_DROP_EN
      drop_cnt_d = drop_cnt_q;
      drop_ph_d  = drop_ph_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (genStateArr_i) begin
               key_d   = key_i;
               state_d = ST_INIT;
            end
         end
         ST_INIT: begin
            s_init_c = 1'b1;
            i_d      = 8'h00;
            j_d      = 8'h00;
            kidx_d   = '0;
            state_d  = ST_KSA;
         end
         ST_KSA: begin
            s_swap_c = 1'b1;
            s_a_c    = i_q;
            s_b_c    = j_ksa_c;
            j_d      = j_ksa_c;
            i_d      = i_inc_c;
            kidx_d   = (kidx_q == KIDX_W'(KEY_BYTES - 1)) ? '0 : kidx_q + KIDX_W'(1);
            if (i_q == 8'hFF) begin
               i_d = 8'h00;
               j_d = 8'h00;
`ifdef RC4_DROP_EN
               drop_cnt_d = '0;
               drop_ph_d  = 1'b0;
               state_d    = ST_DROP;
`else
               sarr_d  = 1'b1;
               state_d = ST_READY;
`endif
            end
         end
`ifdef RC4_DROP_EN
         ST_DROP: begin
            // phase 0 = swap step, phase 1 = discarded output step
            if (!drop_ph_q) begin
               s_swap_c  = 1'b1;
               s_a_c     = i_inc_c;
               s_b_c     = j_prga_c;
               i_d       = i_inc_c;
               j_d       = j_prga_c;
               drop_ph_d = 1'b1;
            end else begin
               drop_ph_d = 1'b0;
               if (drop_cnt_q == DROP_W'(DROP_N - 1)) begin
                  sarr_d  = 1'b1;
                  state_d = ST_READY;
               end else begin
                  drop_cnt_d = drop_cnt_q + DROP_W'(1);
               end
            end
         end
`endif
         ST_READY: begin
            if (genStateArr_i) begin
               key_d   = key_i;
               state_d = ST_INIT;
            end else if (genVal_i && !served_q) begin
               state_d = ST_PRGA_SWAP;
            end
         end
         ST_PRGA_SWAP: begin
            s_swap_c = 1'b1;
            s_a_c    = i_inc_c;
            s_b_c    = j_prga_c;
            i_d      = i_inc_c;
            j_d      = j_prga_c;
            state_d  = ST_PRGA_OUT;
         end
         ST_PRGA_OUT: begin
            out_d    = ks_c;
            val_d    = 1'b1;
            served_d = 1'b1;
            state_d  = ST_READY;
         end
         default: state_d = ST_IDLE;
      endcase

      // A dropped request re-arms the engine for the next byte
      if (!genVal_i) served_d = 1'b0;

      busy_d = !((state_d == ST_IDLE) || (state_d == ST_READY));
   end

   // Control and output registers
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         i_q      <= 8'h00;
         j_q      <= 8'h00;
         kidx_q   <= '0;
         key_q    <= '0;
         served_q <= 1'b0;
         sarr_q   <= 1'b0;
         val_q    <= 1'b0;
         out_q    <= 8'h00;
         busy_q   <= 1'b0;
`ifdef RC4_DROP_EN
         drop_cnt_q <= '0;
         drop_ph_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         j_q      <= j_d;
         kidx_q   <= kidx_d;
         key_q    <= key_d;
         served_q <= served_d;
         sarr_q   <= sarr_d;
         val_q    <= val_d;
         out_q    <= out_d;
         busy_q   <= busy_d;
`ifdef RC4_DROP_EN
         drop_cnt_q <= drop_cnt_d;
         drop_ph_q  <= drop_ph_d;
`endif
      end
   end

   // State array: identity fill or single swap per cycle (a==b leaves S unchanged)
   always_ff @(posedge clk) begin
      if (s_init_c) begin
         for (int k = 0; k < 256; k++) s_q[k] <= 8'(k);
      end else if (s_swap_c) begin
         s_q[s_a_c] <= s_q[s_b_c];
         s_q[s_b_c] <= s_q[s_a_c];
      end
   end

   assign sarrGenerated_o = sarr_q;
   assign valReady_o      = val_q;
   assign outputToXor_o   = out_q;
   assign busy_o          = busy_q;

endmodule
